// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: handshaked, byte-addressable little-endian data memory for the MEM stage.
// Optional macro MISALIGN_TRAP_EN: fault misaligned half/word accesses instead of splitting them byte-wise.
module data_mem_ctrl #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic [1:0]        ls_width,
  input  logic              load_sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_fault
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } ctrlStateT;

  ctrlStateT         stateR;
  ctrlStateT         nextStateS;
  logic [CNT_W-1:0]  cntR;
  logic              writeR;
  logic              memToRegR;
  logic [1:0]        widthR;
  logic              signR;
  logic [ADDR_W-1:0] addrR;
  logic [31:0]       wdataR;
  logic              reqReadyR;
  logic              rspValidR;
  logic [31:0]       rspDataR;
  logic              rspFaultR;

  logic [7:0]        memArr [DEPTH_BYTES];

  logic [3:0]        byteEnS;
  logic [1:0]        lastOffS;
  logic [ADDR_W:0]   lastByteS;
  logic              misalignS;
  logic              faultS;
  logic [IDX_W-1:0]  baseIdxS;
  logic [31:0]       rdWordS;
  logic [31:0]       respDataS;
  logic              commitS;

  function automatic logic [31:0] extendLoad(input logic [31:0] raw, input logic [1:0] width,
                                             input logic sgn);
    logic [31:0] res;
    case (width)
      2'b00:   res = {{24{sgn & raw[7]}}, raw[7:0]};
      2'b01:   res = {{16{sgn & raw[15]}}, raw[15:0]};
      2'b11:   res = raw;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // byte lanes touched by the captured access and offset of its last byte
  always_comb begin
    byteEnS  = 4'b0000;
    lastOffS = 2'd0;
    case (widthR)
      2'b00: begin
        byteEnS  = 4'b0001;
        lastOffS = 2'd0;
      end
      2'b01: begin
        byteEnS  = 4'b0011;
        lastOffS = 2'd1;
      end
      2'b11: begin
        byteEnS  = 4'b1111;
        lastOffS = 2'd3;
      end
      default: begin
        byteEnS  = 4'b0000;
        lastOffS = 2'd0;
      end
    endcase
  end

  // fault detection; the extra address bit keeps addr+offset from wrapping
  always_comb begin
    lastByteS = {1'b0, addrR} + (ADDR_W + 1)'(lastOffS);
`ifdef MISALIGN_TRAP_EN
    misalignS = ((widthR == 2'b01) && addrR[0]) ||
                ((widthR == 2'b11) && (addrR[1:0] != 2'b00));
`else
    misalignS = 1'b0;
`endif
    faultS = (widthR == 2'b10) || ({1'b0, addrR} >= DEPTH_EXT) ||
             (lastByteS >= DEPTH_EXT) || misalignS;
  end

  // read path; index wrap only happens on faulting accesses, whose data is discarded
  always_comb begin
    baseIdxS = addrR[IDX_W-1:0];
    rdWordS  = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      rdWordS[8*k +: 8] = memArr[baseIdxS + IDX_W'(k)];
    end
  end

  // writeback value selection
  always_comb begin
    respDataS = 32'h0000_0000;
    if (faultS) begin
      respDataS = 32'h0000_0000;
    end else if (writeR) begin
      respDataS = 32'h0000_0000;
    end else if (memToRegR) begin
      respDataS = extendLoad(rdWordS, widthR, signR);
    end else begin
      respDataS = 32'(addrR);
    end
  end

  assign commitS = (stateR == BUSY) && (cntR == {CNT_W{1'b0}});

  // next-state logic
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      IDLE: begin
        if (req_valid) nextStateS = BUSY;
        else           nextStateS = IDLE;
      end
      BUSY: begin
        if (cntR == {CNT_W{1'b0}}) nextStateS = RESP;
        else                       nextStateS = BUSY;
      end
      RESP: begin
        if (rsp_ready) nextStateS = IDLE;
        else           nextStateS = RESP;
      end
      default: nextStateS = IDLE;
    endcase
  end

  // state, latency counter and registered handshake/response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR    <= IDLE;
      cntR      <= {CNT_W{1'b0}};
      reqReadyR <= 1'b1;
      rspValidR <= 1'b0;
      rspDataR  <= 32'h0000_0000;
      rspFaultR <= 1'b0;
    end else begin
      stateR    <= nextStateS;
      reqReadyR <= (nextStateS == IDLE);
      rspValidR <= (nextStateS == RESP);
      case (stateR)
        IDLE: begin
          if (req_valid) cntR <= CNT_LOAD;
        end
        BUSY: begin
          if (cntR == {CNT_W{1'b0}}) begin
            rspDataR  <= respDataS;
            rspFaultR <= faultS;
          end else begin
            cntR <= cntR - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // request capture at the accepting edge
  always_ff @(posedge clk) begin
    if (!rst && (stateR == IDLE) && req_valid) begin
      writeR    <= mem_write;
      memToRegR <= mem_to_reg;
      widthR    <= ls_width;
      signR     <= load_sign;
      addrR     <= addr;
      wdataR    <= wdata;
    end
  end

  // store commit; the array itself is never reset
  always_ff @(posedge clk) begin
    if (!rst && commitS && writeR && !faultS) begin
      for (int k = 0; k < 4; k++) begin
        if (byteEnS[k]) memArr[baseIdxS + IDX_W'(k)] <= wdataR[8*k +: 8];
      end
    end
  end

  assign req_ready = reqReadyR;
  assign rsp_valid = rspValidR;
  assign rsp_data  = rspDataR;
  assign rsp_fault = rspFaultR;

  data_mem_ctrl_chk chk (
    .clk       (clk),
    .rst       (rst),
    .req_ready (reqReadyR),
    .rsp_valid (rspValidR),
    .rsp_ready (rsp_ready),
    .rsp_data  (rspDataR),
    .rsp_fault (rspFaultR)
  );

endmodule

// Protocol checker: handshake exclusivity, response stability and zero data on fault.
module data_mem_ctrl_chk (
  input logic        clk,
  input logic        rst,
  input logic        req_ready,
  input logic        rsp_valid,
  input logic        rsp_ready,
  input logic [31:0] rsp_data,
  input logic        rsp_fault
);

  aReadyValidExcl: assert property (@(posedge clk) disable iff (rst) !(req_ready && rsp_valid));

  aRspStable: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_fault)));

  aFaultZero: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && rsp_fault) |-> (rsp_data == 32'h0000_0000));

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl: instance A (LATENCY=3) and instance B (LATENCY=2).
// Misaligned-store expectations follow MISALIGN_TRAP_EN.
module tb_data_mem_ctrl;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic        reqValid [2];
  logic        reqReady [2];
  logic        rspValid [2];
  logic        rspReady [2];
  logic [31:0] rspData  [2];
  logic        rspFault [2];
  logic        memWrite;
  logic        memToReg;
  logic [1:0]  lsWidth;
  logic        loadSign;
  logic [31:0] addr;
  logic [31:0] wdata;

  int compared   = 0;
  int mismatched = 0;

  data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .LATENCY(3)) dutA (
    .clk(clk), .rst(rst[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
    .mem_write(memWrite), .mem_to_reg(memToReg), .ls_width(lsWidth), .load_sign(loadSign),
    .addr(addr), .wdata(wdata), .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]),
    .rsp_data(rspData[0]), .rsp_fault(rspFault[0])
  );

  data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .LATENCY(2)) dutB (
    .clk(clk), .rst(rst[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
    .mem_write(memWrite), .mem_to_reg(memToReg), .ls_width(lsWidth), .load_sign(loadSign),
    .addr(addr), .wdata(wdata), .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]),
    .rsp_data(rspData[1]), .rsp_fault(rspFault[1])
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // one full transaction with rsp_ready held high; inputs change on falling edges
  task automatic doAccess(input int sel, input logic we, input logic m2r, input logic [1:0] w,
                          input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] d, output logic f, output int lat);
    int n;
    @(negedge clk);
    memWrite = we; memToReg = m2r; lsWidth = w; loadSign = sgn; addr = a; wdata = wd;
    rspReady[sel] = 1'b1;
    reqValid[sel] = 1'b1;
    @(negedge clk);
    reqValid[sel] = 1'b0;
    n = 0;
    while (!rspValid[sel] && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkEq("rsp_valid reached", 32'(rspValid[sel]), 32'd1);
    d = rspData[sel];
    f = rspFault[sel];
    lat = n;
  endtask

  task automatic ld(input int sel, input string tag, input logic [1:0] w, input logic sgn,
                    input logic [31:0] a, input logic [31:0] expD, input logic expF);
    logic [31:0] d;
    logic        f;
    int          lat;
    doAccess(sel, 1'b0, 1'b1, w, sgn, a, 32'h0000_0000, d, f, lat);
    checkEq({tag, " data"}, d, expD);
    checkEq({tag, " fault"}, 32'(f), 32'(expF));
  endtask

  task automatic st(input int sel, input string tag, input logic [1:0] w, input logic [31:0] a,
                    input logic [31:0] wd, input logic expF);
    logic [31:0] d;
    logic        f;
    int          lat;
    doAccess(sel, 1'b1, 1'b0, w, 1'b0, a, wd, d, f, lat);
    checkEq({tag, " data"}, d, 32'h0000_0000);
    checkEq({tag, " fault"}, 32'(f), 32'(expF));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [31:0] d;
    logic        f;
    int          lat;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; reqValid[i] = 1'b0; rspReady[i] = 1'b1;
    end
    memWrite = 1'b0; memToReg = 1'b0; lsWidth = 2'b00; loadSign = 1'b0;
    addr = 32'h0; wdata = 32'h0;

    // reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEq("rst req_ready", 32'(reqReady[0]), 32'd1);
    checkEq("rst rsp_valid", 32'(rspValid[0]), 32'd0);
    checkEq("rst rsp_data", rspData[0], 32'h0000_0000);
    checkEq("rst rsp_fault", 32'(rspFault[0]), 32'd0);
    checkEq("rst B req_ready", 32'(reqReady[1]), 32'd1);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // word store then narrower loads, little-endian
    st(0, "st word 0x10", 2'b11, 32'h10, 32'hDEAD_BEEF, 1'b0);
    ld(0, "ldb signed 0x13", 2'b00, 1'b1, 32'h13, 32'hFFFF_FFDE, 1'b0);
    ld(0, "ldh unsigned 0x10", 2'b01, 1'b0, 32'h10, 32'h0000_BEEF, 1'b0);
    ld(0, "ldw 0x10", 2'b11, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    ld(0, "ldh signed 0x12", 2'b01, 1'b1, 32'h12, 32'hFFFF_DEAD, 1'b0);
    ld(0, "ldb unsigned 0x11", 2'b00, 1'b0, 32'h11, 32'h0000_00BE, 1'b0);
    st(0, "st half 0x10", 2'b01, 32'h10, 32'hFFFF_1234, 1'b0);
    st(0, "st byte 0x13", 2'b00, 32'h13, 32'h0000_005A, 1'b0);
    ld(0, "ldw after narrow st", 2'b11, 1'b0, 32'h10, 32'h5AAD_1234, 1'b0);

    // latency 3 with a stalled consumer
    @(negedge clk);
    memWrite = 1'b0; memToReg = 1'b1; lsWidth = 2'b11; loadSign = 1'b0; addr = 32'h10;
    rspReady[0] = 1'b0;
    reqValid[0] = 1'b1;
    @(negedge clk);
    reqValid[0] = 1'b0;
    checkEq("lat3 req_ready busy", 32'(reqReady[0]), 32'd0);
    n = 0;
    while (!rspValid[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkEq("lat3 latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      checkEq("stall rsp_valid", 32'(rspValid[0]), 32'd1);
      checkEq("stall rsp_data", rspData[0], 32'h5AAD_1234);
      checkEq("stall req_ready", 32'(reqReady[0]), 32'd0);
      @(negedge clk);
    end
    rspReady[0] = 1'b1;
    @(negedge clk);
    checkEq("post hs rsp_valid", 32'(rspValid[0]), 32'd0);
    checkEq("post hs req_ready", 32'(reqReady[0]), 32'd1);

    // address pass-through and range faults
    doAccess(0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h24, 32'h0, d, f, lat);
    checkEq("addr wb data", d, 32'h0000_0024);
    checkEq("addr wb fault", 32'(f), 32'd0);
    st(0, "st word top", 2'b11, 32'(DEPTH - 4), 32'h5566_7788, 1'b0);
    st(0, "st word overrun", 2'b11, 32'(DEPTH - 2), 32'hFFFF_FFFF, 1'b1);
    ld(0, "ldw top unchanged", 2'b11, 1'b0, 32'(DEPTH - 4), 32'h5566_7788, 1'b0);
    ld(0, "ldb last byte", 2'b00, 1'b0, 32'(DEPTH - 1), 32'h0000_0055, 1'b0);
    ld(0, "ldh overrun", 2'b01, 1'b0, 32'(DEPTH - 1), 32'h0000_0000, 1'b1);
    ld(0, "ldw out of range", 2'b11, 1'b0, 32'(DEPTH), 32'h0000_0000, 1'b1);
    ld(0, "reserved width", 2'b10, 1'b0, 32'h10, 32'h0000_0000, 1'b1);

    // misaligned word store at 0x21
    st(0, "st word 0x20", 2'b11, 32'h20, 32'h1111_1111, 1'b0);
    st(0, "st word 0x24", 2'b11, 32'h24, 32'h2222_2222, 1'b0);
`ifdef MISALIGN_TRAP_EN
    st(0, "st misaligned", 2'b11, 32'h21, 32'hCAFE_F00D, 1'b1);
    ld(0, "ldw 0x20 unchanged", 2'b11, 1'b0, 32'h20, 32'h1111_1111, 1'b0);
    ld(0, "ldw 0x24 unchanged", 2'b11, 1'b0, 32'h24, 32'h2222_2222, 1'b0);
    ld(0, "ldh misaligned", 2'b01, 1'b0, 32'h21, 32'h0000_0000, 1'b1);
`else
    st(0, "st misaligned", 2'b11, 32'h21, 32'hCAFE_F00D, 1'b0);
    ld(0, "ldw misaligned", 2'b11, 1'b0, 32'h21, 32'hCAFE_F00D, 1'b0);
    ld(0, "ldw 0x20 merged", 2'b11, 1'b0, 32'h20, 32'hFEF0_0D11, 1'b0);
    ld(0, "ldw 0x24 merged", 2'b11, 1'b0, 32'h24, 32'h2222_22CA, 1'b0);
`endif

    // instance B: latency 2, reset one cycle after accepting a store
    doAccess(1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h1122_3344, d, f, lat);
    checkEq("B lat2 latency", 32'(lat), 32'd2);
    checkEq("B st fault", 32'(f), 32'd0);
    @(negedge clk);
    memWrite = 1'b1; memToReg = 1'b0; lsWidth = 2'b11; loadSign = 1'b0;
    addr = 32'h40; wdata = 32'hAABB_CCDD;
    reqValid[1] = 1'b1;
    @(negedge clk);
    reqValid[1] = 1'b0;
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    checkEq("B rst req_ready", 32'(reqReady[1]), 32'd1);
    checkEq("B rst rsp_valid", 32'(rspValid[1]), 32'd0);
    ld(1, "B ldw old data", 2'b11, 1'b0, 32'h40, 32'h1122_3344, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
